// File: rtl/mips_pkg.sv
// Shared MIPS pipeline types and constants for the fetch stage.
package mips_pkg;

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } fetch_state_e;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] PC_STEP   = 32'd4;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & ~32'h3;
  endfunction

endpackage

// File: rtl/if_pc_reg.sv
// Program counter register: synchronous reset, redirect load, sequential increment.
module if_pc_reg
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = mips_pkg::RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_en,
  input  logic [31:0] load_addr,
  input  logic        inc_en,
  output logic [31:0] pc
);

  // Load wins over increment; wrap past 32'hFFFF_FFFC is plain modulo-2^32.
  always_ff @(posedge clk) begin
    if (rst)          pc <= RESET_PC;
    else if (load_en) pc <= word_align(load_addr);
    else if (inc_en)  pc <= pc + PC_STEP;
  end

endmodule

// File: rtl/if_fetch_stage.sv
// MIPS IF stage: owns the PC, drives a req/ack imem port and presents {instruction, PC+4}
// to IF/ID, handling wait states, downstream freeze and EXE redirects.
module if_fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = mips_pkg::RESET_PC,
  parameter logic [31:0] NOP_INSTR = mips_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic [31:0] pc_out,
  output logic        instr_valid
);

  fetch_state_e state;
  logic [31:0]  pc, ibuf, redir_addr, load_addr;
  logic         redir_pend, load_en, inc_en;

  if_pc_reg #(.RESET_PC(RESET_PC)) u_pc (
    .clk       (clk),
    .rst       (rst),
    .load_en   (load_en),
    .load_addr (load_addr),
    .inc_en    (inc_en),
    .pc        (pc)
  );

  assign imem_req  = (state == FETCH) && !rst;
  assign imem_addr = pc;
  assign pc_out    = rst ? RESET_PC + PC_STEP : pc + PC_STEP;

  always_comb begin
    load_en     = 1'b0;
    load_addr   = word_align(branch_addr);
    inc_en      = 1'b0;
    instr_valid = 1'b0;
    instruction = NOP_INSTR;
    if (!rst) begin
      case (state)
        FETCH: if (imem_ack) begin
          // A redirect (live or latched while waiting) squashes the returning word.
          if (branch_taken || redir_pend) begin
            load_en   = 1'b1;
            load_addr = branch_taken ? word_align(branch_addr) : redir_addr;
          end else begin
            instr_valid = 1'b1;
            instruction = imem_rdata;
            inc_en      = !freeze;
          end
        end
        HOLD: begin
          instruction = ibuf;
          if (branch_taken) begin
            load_en = 1'b1;
          end else begin
            instr_valid = 1'b1;
            inc_en      = !freeze;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FETCH;
      ibuf       <= '0;
      redir_pend <= 1'b0;
      redir_addr <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (imem_ack) begin
            if (branch_taken || redir_pend) begin
              redir_pend <= 1'b0;
            end else if (freeze) begin
              ibuf  <= imem_rdata;
              state <= HOLD;
            end
          end else if (branch_taken) begin
            // Request address stays put; newest redirect overwrites any older one.
            redir_pend <= 1'b1;
            redir_addr <= word_align(branch_addr);
          end
        end
        HOLD: if (branch_taken || !freeze) state <= FETCH;
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
Instruction fetch stage of the 5-stage MIPS pipeline. It owns the program counter and drives a req/ack instruction-memory port. It presents {instruction, PC+4} each cycle to the IF/ID pipeline register downstream. It absorbs variable memory latency, downstream freeze and branch redirects from EXE, and inserts NOP bubbles when no instruction is ready.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0000, instruction word driven when instr_valid=0

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
freeze  in  1  downstream hazard stall; the current instruction is not consumed this cycle
branch_taken  in  1  EXE redirect request, single-cycle pulse
branch_addr  in  32  redirect target; bits [1:0] ignored (forced 00)
imem_req  out  1  memory request valid
imem_addr  out  32  word-aligned fetch address
imem_ack  in  1  read data valid; may assert in the same cycle as imem_req (zero-wait memory)
imem_rdata  in  32  read data, valid only when imem_ack=1
instruction  out  32  instruction to IF/ID register
pc_out  out  32  fetch PC + 4, to IF/ID register
instr_valid  out  1  instruction/pc_out hold a real instruction; 0 means bubble

Behaviour:
- Reset:
  - pc=RESET_PC, state=FETCH, redir_pend=0, ibuf=0.
  - While rst=1: imem_req=0, instr_valid=0, instruction=NOP_INSTR, pc_out=RESET_PC+4.
- Registers: pc[31:0], state {FETCH, HOLD}, ibuf[31:0], redir_pend, redir_addr[31:0].
- pc arithmetic: modulo 2^32, so 32'hFFFF_FFFC+4 wraps to 0. pc[1:0] is always 00.
- pc_out = pc+4 (combinational, from the current pc) in every state.
- Handshake:
  - imem_req=1 exactly when state=FETCH and rst=0.
  - imem_addr=pc, held stable while req=1 and ack=0.
  - A transfer completes on the cycle with req=1 and ack=1.
- FETCH, priority top-down:
  1. ack & (branch_taken | redir_pend): discard data; instr_valid=0; pc<=branch_taken ? branch_addr : redir_addr; redir_pend<=0; stay FETCH.
  2. ack & ~freeze: instr_valid=1, instruction=imem_rdata (combinational bypass); pc<=pc+4; stay FETCH. Throughput is 1 instr/cycle with zero-wait memory.
  3. ack & freeze: ibuf<=imem_rdata; instr_valid=1 (presented but not consumed); goto HOLD; pc unchanged.
  4. ~ack & branch_taken: redir_pend<=1, redir_addr<=branch_addr; the address does not change mid-request; instr_valid=0.
  5. ~ack: instr_valid=0, instruction=NOP_INSTR.
- HOLD (imem_req=0, instruction=ibuf, instr_valid=1 unless rule 1 applies):
  1. branch_taken: instr_valid=0; pc<=branch_addr; goto FETCH.
  2. ~freeze: instruction consumed this cycle; pc<=pc+4; goto FETCH.
  3. freeze: stay HOLD; all outputs constant.
- Branch wins over freeze in every state.
- A second branch_taken while redir_pend=1 overwrites redir_addr (newest wins).
- Reset mid-request: the in-flight request is abandoned. The memory shares rst, and any ack in the reset cycle is ignored.
- Latency: with zero-wait memory, a redirect in cycle N makes the target issue in cycle N+1, and its instruction is valid in N+1.

Decomposition:
- Shared package mips_pkg: fetch state enum {FETCH, HOLD}, NOP_INSTR, RESET_PC, PC_STEP=4.
- One natural sub-module, if_pc_reg: the pc register with reset/load/increment. Inputs: load_en, load_addr, inc_en. Output: pc.
- FSM, redirect latch and ibuf stay in the top level.

Test Plan:
1. Zero-wait memory (ack=req), no stalls, from reset: imem_addr 0,4,8,12 on consecutive cycles; instr_valid=1 every cycle; pc_out 4,8,12,16.
2. Memory with 2-cycle wait, 32'hDEAD_BEEF returned: req high 3 cycles, addr stable, valid=0 then 1 on the ack cycle. pc advances only after the ack.
3. Ack while freeze=1 for 3 cycles: state HOLD, instruction=ibuf constant, req=0. Freeze drop, then consumed and next req at pc+4.
4. branch_taken with branch_addr=32'h0000_0100 during a pending request (ack 2 cycles later): the acked data is discarded (valid=0). The next request is at 0x100, with no intermediate address issued.
5. branch_taken and freeze together while in HOLD: ibuf dropped, valid=0, next cycle req at the target; branch wins.
6. Reset asserted mid-request and during HOLD: next cycle req=0, valid=0, instruction=0. After release the first req is at RESET_PC. Also cover the pc=32'hFFFF_FFFC wrap: next address is 0.
